conv3x3_engine: RTL and testbench

//  Downstream of the rows builder. Consumes pixel columns (`N_ROWS x `WIDTH, unsigned) one per handshake and

---
 rtl/data_types_pkg.sv | 20 ++
 rtl/conv3x3_mac.sv | 35 +++
 rtl/conv3x3_engine.sv | 128 ++++++++++++
 tb/tb_conv3x3_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_types_pkg.sv
// Shared types for the 3x3 convolution engine: FSM state encoding and kernel storage.
`ifndef N_ROWS
`define N_ROWS 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

package data_types_pkg;

  typedef enum logic [1:0] {IDLE, FILL, CALC, DONE} conv_state_t;

  localparam int unsigned KERNEL_TAPS = 9;
  localparam int unsigned TAP_W       = 8;

  typedef logic signed [TAP_W-1:0] tap_t;
  // Tap index = row*3 + col.
  typedef tap_t [KERNEL_TAPS-1:0] kernel_t;

endpackage

// File: rtl/conv3x3_mac.sv
// Combinational 9-term dot product of an unsigned 3x3 pixel patch with a signed kernel.
`ifndef N_ROWS
`define N_ROWS 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module conv3x3_mac
  import data_types_pkg::*;
#(
  parameter int unsigned ACC_W = `WIDTH + TAP_W + 5
) (
  input  logic [2:0][2:0][`WIDTH-1:0] patch,  // [row][col]
  input  kernel_t                     kern,
  output logic signed [ACC_W-1:0]     sum
);

  logic signed [ACC_W-1:0] px;
  logic signed [ACC_W-1:0] tk;

  always_comb begin
    sum = '0;
    px  = '0;
    tk  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        px  = {{(ACC_W-`WIDTH){1'b0}}, patch[2'(i)][2'(j)]};
        tk  = {{(ACC_W-TAP_W){kern[4'(i*3+j)][TAP_W-1]}}, kern[4'(i*3+j)]};
        sum = sum + px * tk;
      end
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// 3-column sliding-window 3x3 convolution engine with column/result handshakes.
// Optional build macro CONV3X3_RELU_EN clamps negative results to zero.
`ifndef N_ROWS
`define N_ROWS 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module conv3x3_engine
  import data_types_pkg::*;
#(
  parameter int unsigned N_COLS = 8,
  parameter int unsigned KW     = TAP_W,
  parameter int unsigned ACC_W  = `WIDTH + KW + 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              conv_start,
  input  logic                              kern_we,
  input  logic [3:0]                        kern_addr,
  input  logic [KW-1:0]                     kern_data,
  input  logic                              col_valid,
  output logic                              col_ready,
  input  logic [`N_ROWS-1:0][`WIDTH-1:0]    col_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [ACC_W-1:0]           res_data,
  output logic [$clog2(`N_ROWS)-1:0]        res_row,
  output logic [$clog2(N_COLS)-1:0]         res_col,
  output logic                              frame_done
);

  localparam int unsigned CNT_W = $clog2(N_COLS + 1);
  localparam int unsigned ROW_W = $clog2(`N_ROWS);
  localparam int unsigned COL_W = $clog2(N_COLS);

  conv_state_t state, state_nxt;

  logic [`N_ROWS-1:0][`WIDTH-1:0] win [3];
  logic [CNT_W-1:0]               col_cnt;
  logic [ROW_W-1:0]               row_r;
  kernel_t                        kern;

  logic                           last_row;
  logic [2:0][2:0][`WIDTH-1:0]    patch;
  logic signed [ACC_W-1:0]        sum;

  assign last_row = (row_r == ROW_W'(`N_ROWS - 3));

  always_comb begin
    state_nxt  = state;
    col_ready  = 1'b0;
    res_valid  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (conv_start) state_nxt = FILL;
      FILL: begin
        col_ready = 1'b1;
        // The accepted column makes the count >= 3.
        if (col_valid && col_cnt >= CNT_W'(2)) state_nxt = CALC;
      end
      CALC: begin
        res_valid = 1'b1;
        if (res_ready && last_row)
          state_nxt = (col_cnt < CNT_W'(N_COLS)) ? FILL : DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      win[0]  <= '0;
      win[1]  <= '0;
      win[2]  <= '0;
      col_cnt <= '0;
      row_r   <= '0;
      kern    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && kern_we && kern_addr < 4'd9)
        kern[kern_addr] <= tap_t'(kern_data);
      if (col_valid && col_ready) begin
        win[0]  <= win[1];
        win[1]  <= win[2];
        win[2]  <= col_in;
        col_cnt <= col_cnt + CNT_W'(1);
      end
      if (res_valid && res_ready)
        row_r <= last_row ? '0 : row_r + ROW_W'(1);
      if (state == DONE) begin
        col_cnt <= '0;
        row_r   <= '0;
      end
    end
  end

  // win[0] is the leftmost (oldest) column of the window.
  always_comb begin
    patch = '0;
    for (int unsigned i = 0; i < 3; i++)
      for (int unsigned j = 0; j < 3; j++)
        patch[2'(i)][2'(j)] = win[2'(j)][ROW_W'(row_r + ROW_W'(i))];
  end

  conv3x3_mac #(.ACC_W(ACC_W)) u_mac (
    .patch (patch),
    .kern  (kern),
    .sum   (sum)
  );

  always_comb begin
`ifdef CONV3X3_RELU_EN
    res_data = sum[ACC_W-1] ? '0 : sum;
`else
    res_data = sum;
`endif
    res_row = row_r;
    res_col = COL_W'(col_cnt - CNT_W'(3));
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: driver queues expected results, monitor pops on each handshake.
`ifndef N_ROWS
`define N_ROWS 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_conv3x3_engine;

  localparam int NR    = `N_ROWS;
  localparam int W     = `WIDTH;
  localparam int NC    = 8;
  localparam int KW    = 8;
  localparam int ACC_W = W + KW + 5;
  localparam int NRES  = (NC - 2) * (NR - 2);

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        conv_start = 1'b0;
  logic                        kern_we = 1'b0;
  logic [3:0]                  kern_addr = '0;
  logic [KW-1:0]               kern_data = '0;
  logic                        col_valid = 1'b0;
  logic                        col_ready;
  logic [NR-1:0][W-1:0]        col_in = '0;
  logic                        res_valid;
  logic                        res_ready = 1'b1;
  logic signed [ACC_W-1:0]     res_data;
  logic [$clog2(NR)-1:0]       res_row;
  logic [$clog2(NC)-1:0]       res_col;
  logic                        frame_done;

  conv3x3_engine #(.N_COLS(NC), .KW(KW), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .conv_start (conv_start),
    .kern_we    (kern_we),
    .kern_addr  (kern_addr),
    .kern_data  (kern_data),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_in     (col_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_col    (res_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     row;
    int     col;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   hs_cnt = 0;
  int   fd_cnt = 0;
  bit   abort  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: one pop per result handshake (sampled mid-cycle, handshake happens at next posedge).
  always @(negedge clk) begin
    exp_t e;
    if (rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("res_data", longint'(res_data), e.data);
        chk("res_row", longint'(res_row), e.row);
        chk("res_col", longint'(res_col), e.col);
      end
      hs_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  function automatic int pix(input int pat, input int c, input int r);
    case (pat)
      0:       return 10 * c + r;
      1:       return 255;
      default: return 100;
    endcase
  endfunction

  // Hand-derived closed forms for each kernel/pixel pairing.
  function automatic longint exp_val(input int tst, input int r, input int c);
    case (tst)
      1: return 10 * (c + 1) + (r + 1);
      2: return 2295;
`ifdef CONV3X3_RELU_EN
      4: return 0;
`else
      4: return -100;
`endif
      7: return 20 * c + 2 * r + 30;
      default: return 0;
    endcase
  endfunction

  task automatic write_tap(input int a, input int d);
    @(posedge clk); #1;
    kern_we = 1'b1; kern_addr = 4'(a); kern_data = KW'(d);
    @(posedge clk); #1;
    kern_we = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (hs_cnt < target && t < 2000);
    if (hs_cnt < target) chk("wait_hs_timeout", hs_cnt, target);
  endtask

  task automatic send_cols(input int pat);
    for (int c = 0; c < NC; c++) begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!col_ready && !abort && t < 300);
      if (abort) begin col_valid = 1'b0; return; end
      if (!col_ready) begin chk("col_ready_timeout", 0, 1); return; end
      for (int r = 0; r < NR; r++) col_in[r] = W'(pix(pat, c, r));
      col_valid = 1'b1;
      @(posedge clk); #1;
      col_valid = 1'b0;
      if (c == 2 && !abort) begin
        @(negedge clk);
        chk("first_result_latency", res_valid, 1);
      end
    end
  endtask

  // mode 0: plain, 1: result stall, 2: reset abort, 3: control noise during frame
  task automatic side(input int mode, input int base);
    case (mode)
      1: begin
        wait_hs(base + 10);
        res_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_res_valid", res_valid, 1);
          chk("stall_col_ready", col_ready, 0);
          if (sb_q.size() > 0) begin
            chk("stall_res_data", longint'(res_data), sb_q[0].data);
            chk("stall_res_row", longint'(res_row), sb_q[0].row);
            chk("stall_res_col", longint'(res_col), sb_q[0].col);
          end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
      2: begin
        wait_hs(base + 8);
        rst = 1'b0;
        abort = 1'b1;
        #1;
        chk("reset_res_valid", res_valid, 0);
        chk("reset_col_ready", col_ready, 0);
        chk("reset_frame_done", frame_done, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
      end
      3: begin
        @(posedge clk); #1;
        conv_start = 1'b1; kern_we = 1'b1; kern_addr = 4'd4; kern_data = KW'(50);
        wait_hs(base + 9);
        conv_start = 1'b0; kern_we = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int pat, input int tst, input bit wr_with_start,
                           input int wa, input int wd, input int mode);
    int base;
    int fd0;
    int t;
    for (int c = 0; c < NC - 2; c++)
      for (int r = 0; r < NR - 2; r++)
        sb_q.push_back('{exp_val(tst, r, c), r, c});
    base = hs_cnt;
    fd0  = fd_cnt;
    @(posedge clk); #1;
    conv_start = 1'b1;
    if (wr_with_start) begin
      kern_we = 1'b1; kern_addr = 4'(wa); kern_data = KW'(wd);
    end
    @(posedge clk); #1;
    conv_start = 1'b0; kern_we = 1'b0;
    fork
      send_cols(pat);
      side(mode, base);
    join
    abort = 1'b0;
    if (mode == 2) return;
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < 300);
    chk("frame_done_seen", frame_done, 1);
    chk("handshakes_before_done", hs_cnt - base, NRES);
    chk("scoreboard_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 0);
    chk("frame_done_pulses", fd_cnt - fd0, 1);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_col_ready", col_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Center tap written in the same cycle as conv_start.
    run_frame(0, 1, 1'b1, 4, 1, 0);
    run_frame(0, 1, 1'b0, 0, 0, 1);
    run_frame(0, 1, 1'b0, 0, 0, 3);

    for (int a = 0; a < 9; a++) write_tap(a, 1);
    run_frame(1, 2, 1'b0, 0, 0, 0);

    for (int a = 0; a < 9; a++) write_tap(a, (a == 4) ? -1 : 0);
    run_frame(2, 4, 1'b0, 0, 0, 0);

    for (int a = 0; a < 9; a++) write_tap(a, (a == 0) ? 1 : (a == 5) ? 2 : (a == 7) ? -1 : 0);
    run_frame(0, 7, 1'b0, 0, 0, 0);

    run_frame(0, 7, 1'b0, 0, 0, 2);
    @(negedge clk);
    chk("post_reset_idle_col_ready", col_ready, 0);
    chk("post_reset_idle_res_valid", res_valid, 0);
    // Kernel cleared by reset: every result must be zero.
    run_frame(0, 5, 1'b0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
